fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the OpenMIPS core. It owns the program counter and instruction-ROM enable, and issues word addresses to a synchronous instruction ROM. Returned instructions are buffered in a small FIFO and presented to the decode stage over a valid/ready handshake. It also handles branch redirect and halt/resume from the control unit.

Parameters:
PC_WIDTH, 6, width of ROM word address / pc.
INST_WIDTH, 32, instruction width.
FIFO_DEPTH, 4, fetch buffer entries; must be a power of 2, at least 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
halt_i  in  1  stop issuing new fetches while high.
branch_flag_i  in  1  redirect request, single-cycle pulse.
branch_target_i  in  PC_WIDTH  redirect word address.
pc  out  PC_WIDTH  ROM address (registered).
ce  out  1  ROM enable (registered); an issue occurs in every cycle with ce=1.
inst_i  in  INST_WIDTH  ROM data; equals mem[pc] in the cycle after the issue.
if_valid_o  out  1  head FIFO entry valid.
if_pc_o  out  PC_WIDTH  pc of head entry.
if_inst_o  out  INST_WIDTH  instruction of head entry.
id_ready_i  in  1  decode accepts the head entry when if_valid_o and id_ready_i are both high.

Behaviour:
- Reset (rst=0, asynchronous): pc=0, ce=0, FIFO empty, if_valid_o=0, if_pc_o=0, if_inst_o=0, in-flight tags cleared, state=IDLE. Reset asserted mid-stream discards everything immediately.
- FSM states: IDLE, RUN, HALT.
  - IDLE: ce=0. The first edge after reset release moves to RUN; no issue in IDLE.
  - RUN: issue when occ + inflight - pop < FIFO_DEPTH.
    - occ = FIFO occupancy; inflight = issues not yet captured (0..2); pop = if_valid_o & id_ready_i.
    - On issue: ce=1 for that cycle. The first issue after IDLE uses pc=0; every later issue uses pc+1 (mod 2^PC_WIDTH, 63 wraps to 0).
    - No issue: ce=0, pc held.
  - RUN to HALT: when halt_i=1. While in HALT, ce=0 and pc is held. In-flight fetches are still captured and the FIFO keeps draining.
  - HALT to RUN: when halt_i=0. The next issue is pc+1.
- Latency: an issue at edge E0 (pc=A, ce=1) is sampled by the ROM at E1. The controller captures {A, inst_i} into the FIFO at E2, so if_valid_o can be high after E2. Minimum latency is 2 cycles; with no backpressure, throughput is 1 per cycle.
- In-flight tracking: a 2-stage tag shift register {valid, pc} parallel to the ROM. Stage 2 writes the FIFO. Push and pop in the same cycle are legal; occupancy is unchanged.
- Branch (branch_flag_i=1 at an edge, any state except IDLE):
  - pc=branch_target_i, ce=1: the target is issued at that edge.
  - FIFO flushed, both in-flight tags invalidated, if_valid_o=0 next cycle.
  - A pop in the same cycle is still counted as accepted by decode.
  - If halt_i is also high, the target is still issued, then the block enters HALT. Branch wins over halt and over backpressure.
- FIFO full with id_ready_i=0: the credit rule guarantees no overflow and no ce; nothing is dropped or duplicated.
- Empty FIFO: if_valid_o=0, and if_pc_o / if_inst_o output 0.
- Occupancy counter width: log2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package cpu_defs:
  - PC_WIDTH, INST_WIDTH.
  - ZERO_WORD = 32'h0 (also used as NOP).
  - FSM state encodings FETCH_IDLE=2'd0, FETCH_RUN=2'd1, FETCH_HALT=2'd2.
- One sub-module, fetch_fifo:
  - Synchronous FIFO of {pc, inst}, parameterised by FIFO_DEPTH.
  - push/pop/flush inputs; head, empty, full and count outputs; async active-low reset.
- The FSM, credit logic and in-flight tags stay in fetch_ctrl.

Test Plan:
1. Reset release, id_ready_i=1, ROM mem[k]=k+32'h100:
   - Edge 1: IDLE to RUN.
   - pc runs 0,1,2,…, with ce=1 every cycle.
   - if_valid_o is high from 2 cycles after the first issue.
   - if_pc_o/if_inst_o sequence: 0/0x100, 1/0x101, … with no gaps.
2. Backpressure: id_ready_i=0 for 8 cycles mid-stream:
   - ce drops once occ+inflight reaches 4; occupancy never exceeds 4.
   - On release, delivered pcs are contiguous, with no drop or duplicate.
3. Branch to 6'd20 while FIFO holds 3 entries and 2 are in flight:
   - if_valid_o=0 next cycle.
   - The next delivered if_pc_o=20, then 21, 22; no stale entry ever appears.
4. Wrap: run from pc=62 -> delivered pcs 62, 63, 0, 1; ce stays continuous.
5. halt_i=1 for 5 cycles:
   - ce=0 and pc frozen.
   - FIFO drains to empty.
   - On halt_i=0, fetch resumes at pc+1.
   - A branch pulse together with halt_i: the target is fetched once, then the block halts.
6. rst=0 asserted asynchronously mid-stream with FIFO full -> pc, ce, if_valid_o, if_pc_o and if_inst_o all go to 0 immediately; after release the sequence restarts from pc 0.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared widths, constants, fetch FSM states and fetch buffer entry type
package cpu_defs;
    localparam int PC_WIDTH = 6;
    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] ZERO_WORD = 32'h0;
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;
    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch-to-decode valid/ready handshake
interface fetch_ctrl_if;
    import cpu_defs::*;
    logic                  if_valid_o;
    logic [PC_WIDTH-1:0]   if_pc_o;
    logic [INST_WIDTH-1:0] if_inst_o;
    logic                  id_ready_i;
    modport master (output if_valid_o, if_pc_o, if_inst_o, input id_ready_i);
    modport slave (input if_valid_o, if_pc_o, if_inst_o, output id_ready_i);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, inst} with flush; head reads as zero when empty
module fetch_fifo
    import cpu_defs::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  fetch_entry_t                push_data_i,
    output fetch_entry_t                head_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    fetch_entry_t  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    // pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_i);
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    // storage needs no reset: the head is masked while empty
    always_ff @(posedge clk)
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? fetch_entry_t'{pc: '0, inst: ZERO_WORD} : mem_q[rd_q];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: pc/ROM-enable sequencer with credit-based fetch buffer, branch redirect and halt
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt_i,
    input  logic                  branch_flag_i,
    input  logic [PC_WIDTH-1:0]   branch_target_i,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  ce,
    input  logic [INST_WIDTH-1:0] inst_i,
    fetch_ctrl_if.master          id_if
);
    fetch_state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]         pc_q, pc_d, t1_pc_q, t2_pc_q;
    logic                        ce_q, started_q, started_d, t1_v_q, t2_v_q;
    logic                        branch, run_issue, issue, credit_ok, pop, push;
    logic                        fifo_empty, fifo_full;
    logic [$clog2(FIFO_DEPTH):0] occ;
    fetch_entry_t                head;
    assign pop       = id_if.if_valid_o & id_if.id_ready_i;
    assign push      = t2_v_q & (!fifo_full | pop);
    assign credit_ok = 32'(occ) + 32'(t1_v_q) + 32'(t2_v_q) < 32'(FIFO_DEPTH) + 32'(pop);
    // next state, issue decision and next pc; a branch always issues its target
    always_comb begin
        branch    = branch_flag_i && state_q != FETCH_IDLE;
        run_issue = state_q == FETCH_RUN && !halt_i && credit_ok;
        issue     = branch || run_issue;
        pc_d      = branch ? branch_target_i : (run_issue && started_q) ? pc_q + PC_WIDTH'(1) : pc_q;
        started_d = started_q | issue;
        state_d   = state_q == FETCH_IDLE ? FETCH_RUN : halt_i ? FETCH_HALT : FETCH_RUN;
    end
    // state, pc and the two-stage in-flight tag pipe that shadows the ROM latency
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= '0;
            ce_q      <= 1'b0;
            started_q <= 1'b0;
            t1_v_q    <= 1'b0;
            t2_v_q    <= 1'b0;
            t1_pc_q   <= '0;
            t2_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ce_q      <= issue;
            started_q <= started_d;
            t1_v_q    <= issue;
            t1_pc_q   <= pc_d;
            t2_v_q    <= t1_v_q & !branch;
            t2_pc_q   <= t1_pc_q;
        end
    fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (branch),
        .push_data_i (fetch_entry_t'{pc: t2_pc_q, inst: inst_i}),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (occ)
    );
    assign pc               = pc_q;
    assign ce               = ce_q;
    assign id_if.if_valid_o = !fifo_empty;
    assign id_if.if_pc_o    = head.pc;
    assign id_if.if_inst_o  = head.inst;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a synchronous ROM model
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i, branch_flag_i;
    logic [5:0]  branch_target_i, pc;
    logic        ce;
    logic [31:0] inst_i;
    logic [31:0] mem [64];
    logic [5:0]  exp_q [$];
    int          n_vec = 0, n_err = 0, n_pop = 0, outstanding = 0, peak = 0, pop_mark;

    fetch_ctrl_if id_if ();

    fetch_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .halt_i          (halt_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .pc              (pc),
        .ce              (ce),
        .inst_i          (inst_i),
        .id_if           (id_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ce) inst_i <= mem[pc];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic restart(input logic [5:0] start);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(start + 6'(i));
        outstanding = 0;
    endtask

    task automatic tick();
        logic [5:0] e;
        @(negedge clk);
        outstanding += int'(ce);
        if (outstanding > peak) peak = outstanding;
        if (id_if.if_valid_o && id_if.id_ready_i) begin
            n_pop++;
            outstanding--;
            if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(id_if.if_pc_o), 32'(e));
                check("sb_inst", id_if.if_inst_o, 32'(e) + 32'h100);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [5:0] t);
        branch_flag_i = 1'b1;
        branch_target_i = t;
        tick();
        branch_flag_i = 1'b0;
        restart(t);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'(k) + 32'h100;
        rst = 1'b0;
        halt_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        id_if.id_ready_i = 1'b1;
        repeat (2) tick();
        check("rst_pc", 32'(pc), 0);
        check("rst_ce", 32'(ce), 0);
        check("rst_valid", 32'(id_if.if_valid_o), 0);
        check("rst_if_pc", 32'(id_if.if_pc_o), 0);
        check("rst_if_inst", id_if.if_inst_o, 0);
        // start-up: idle edge, first issue at pc 0, two-cycle latency
        rst = 1'b1;
        restart(6'd0);
        tick();
        check("idle_ce", 32'(ce), 0);
        tick();
        check("first_ce", 32'(ce), 1);
        check("first_pc", 32'(pc), 0);
        tick();
        check("second_pc", 32'(pc), 1);
        check("lat_valid0", 32'(id_if.if_valid_o), 0);
        tick();
        check("lat_valid1", 32'(id_if.if_valid_o), 1);
        check("lat_if_pc", 32'(id_if.if_pc_o), 0);
        check("lat_if_inst", id_if.if_inst_o, 32'h100);
        repeat (10) tick();
        // backpressure
        id_if.id_ready_i = 1'b0;
        repeat (8) tick();
        check("bp_ce", 32'(ce), 0);
        check("bp_valid", 32'(id_if.if_valid_o), 1);
        check("bp_peak", 32'(peak), 4);
        id_if.id_ready_i = 1'b1;
        repeat (10) tick();
        // branch with entries buffered and in flight
        id_if.id_ready_i = 1'b0;
        tick();
        branch_to(6'd20);
        check("br_valid", 32'(id_if.if_valid_o), 0);
        check("br_ce", 32'(ce), 1);
        check("br_pc", 32'(pc), 20);
        id_if.id_ready_i = 1'b1;
        repeat (8) tick();
        // wrap through 63 -> 0 with continuous issue
        branch_to(6'd62);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("wrap_ce", 32'(ce), 1);
        end
        check("wrap_pc", 32'(pc), 6);
        // halt: pc frozen, buffer drains, resume at pc+1
        halt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_ce", 32'(ce), 0);
            check("halt_pc", 32'(pc), 6);
        end
        check("halt_drained", 32'(id_if.if_valid_o), 0);
        halt_i = 1'b0;
        tick();
        check("resume_ce0", 32'(ce), 0);
        tick();
        check("resume_ce1", 32'(ce), 1);
        check("resume_pc", 32'(pc), 7);
        // branch together with halt: target fetched once, then halted
        halt_i = 1'b1;
        branch_to(6'd40);
        check("brh_ce", 32'(ce), 1);
        check("brh_pc", 32'(pc), 40);
        pop_mark = n_pop;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("brh_halt_ce", 32'(ce), 0);
        end
        check("brh_pc_held", 32'(pc), 40);
        check("brh_delivered", 32'(n_pop - pop_mark), 1);
        halt_i = 1'b0;
        repeat (8) tick();
        // asynchronous reset with a full buffer
        id_if.id_ready_i = 1'b0;
        repeat (6) tick();
        check("full_valid", 32'(id_if.if_valid_o), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_pc", 32'(pc), 0);
        check("arst_ce", 32'(ce), 0);
        check("arst_valid", 32'(id_if.if_valid_o), 0);
        check("arst_if_pc", 32'(id_if.if_pc_o), 0);
        check("arst_if_inst", id_if.if_inst_o, 0);
        exp_q.delete();
        outstanding = 0;
        repeat (2) tick();
        rst = 1'b1;
        restart(6'd0);
        id_if.id_ready_i = 1'b1;
        tick();
        check("re_idle_ce", 32'(ce), 0);
        tick();
        check("re_ce", 32'(ce), 1);
        check("re_pc", 32'(pc), 0);
        pop_mark = n_pop;
        repeat (8) tick();
        check("re_delivered", 32'(n_pop - pop_mark), 6);
        check("final_peak", 32'(peak), 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
